// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, boots from the BIOS ROM, then switches to main instruction memory
// on Start System, and stops for good on Hlt or when the PC runs past the end of the BIOS.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BIOS_DEPTH   = 37,
  parameter logic [ADDR_WIDTH-1:0] SYS_START_PC = 12'd0,
  parameter logic [5:0]            OP_START     = 6'b100111,
  parameter logic [5:0]            OP_HALT      = 6'b011100,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h6C00_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  input  logic [DATA_WIDTH-1:0] bios_data,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  system_mode,
  output logic                  halted,
  output logic                  bios_overrun
);

  typedef enum logic [1:0] {
    BIOS_RUN   = 2'd0,
    SYSTEM_RUN = 2'd1,
    HALTED     = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BIOS_LIMIT = ADDR_WIDTH'(BIOS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE     = ADDR_WIDTH'(1);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
  logic [DATA_WIDTH-1:0]   instr_r, instr_s;
  logic [ADDR_WIDTH-1:0]   instr_pc_r, instr_pc_s;
  logic                    instr_valid_r, instr_valid_s;
  logic                    system_mode_r, system_mode_s;
  logic                    halted_r, halted_s;
  logic                    bios_overrun_r, bios_overrun_s;
  logic [DATA_WIDTH-1:0]   fetch_word_s;
  logic [5:0]              opcode_s;

  assign fetch_word_s = system_mode_r ? imem_data : bios_data;
  assign opcode_s     = fetch_word_s[DATA_WIDTH-1 -: 6];

  // Next-state and next-output logic; every register holds unless a rule below changes it.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    instr_s        = instr_r;
    instr_pc_s     = instr_pc_r;
    instr_valid_s  = instr_valid_r;
    system_mode_s  = system_mode_r;
    halted_s       = halted_r;
    bios_overrun_s = bios_overrun_r;
    case (state_r)
      BIOS_RUN, SYSTEM_RUN: begin
        if (redirect_valid) begin
          // Whatever was fetched this cycle is on the wrong path, Start/Hlt included.
          pc_s          = redirect_target;
          instr_s       = NOP_WORD;
          instr_valid_s = 1'b0;
        end else if (stall) begin
          state_s = state_r;
        end else if ((state_r == BIOS_RUN) && (pc_r >= BIOS_LIMIT)) begin
          state_s        = HALTED;
          halted_s       = 1'b1;
          bios_overrun_s = 1'b1;
          instr_valid_s  = 1'b0;
        end else if ((state_r == BIOS_RUN) && (opcode_s == OP_START)) begin
          state_s       = SYSTEM_RUN;
          system_mode_s = 1'b1;
          pc_s          = SYS_START_PC;
          instr_s       = NOP_WORD;
          instr_valid_s = 1'b0;
        end else if (opcode_s == OP_HALT) begin
          state_s       = HALTED;
          halted_s      = 1'b1;
          instr_s       = fetch_word_s;
          instr_pc_s    = pc_r;
          instr_valid_s = 1'b1;
        end else begin
          instr_s       = fetch_word_s;
          instr_pc_s    = pc_r;
          instr_valid_s = 1'b1;
          pc_s          = pc_r + PC_ONE;
        end
      end
      HALTED: begin
        instr_valid_s = 1'b0;
      end
      default: begin
        // Unreachable encoding: stop fetching rather than run from an unknown state.
        state_s       = HALTED;
        halted_s      = 1'b1;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= BIOS_RUN;
      pc_r           <= '0;
      instr_r        <= NOP_WORD;
      instr_pc_r     <= '0;
      instr_valid_r  <= 1'b0;
      system_mode_r  <= 1'b0;
      halted_r       <= 1'b0;
      bios_overrun_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      instr_r        <= instr_s;
      instr_pc_r     <= instr_pc_s;
      instr_valid_r  <= instr_valid_s;
      system_mode_r  <= system_mode_s;
      halted_r       <= halted_s;
      bios_overrun_r <= bios_overrun_s;
    end
  end

  assign fetch_address = pc_r;
  assign instr         = instr_r;
  assign instr_pc      = instr_pc_r;
  assign instr_valid   = instr_valid_r;
  assign system_mode   = system_mode_r;
  assign halted        = halted_r;
  assign bios_overrun  = bios_overrun_r;

endmodule
